uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Parametrised UART transmitter for the FPGA serial link. It replaces the fixed 8N1 transmitter with configurable data width, parity and stop-bit count, and uses a clean valid/ready input handshake. Baud timing comes from an internal clock-enable divider, so the whole block runs on the system clock with no derived clocks. It sits between the byte producer (register bank or TX FIFO) and the `sdata_tx_out` pad.

## Interface
- `DATA_BITS`, 8: payload width, legal 5..9.
- `STOP_BITS`, 1: stop bits per frame, legal 1 or 2.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even. Ignored unless `UART_TX_PARITY_EN` is defined.
- `CLOCK_INPUT`, 50_000_000: system clock frequency in Hz.
- `BAUDRATE`, 115200: line rate in bit/s.
- `clock`, input, 1: single system clock, rising edge.
- `nreset`, input, 1: reset, synchronous, active-low.
- `valid_tx_in`, input, 1: producer has a word on `data_tx_in`.
- `data_tx_in`, input, DATA_BITS: payload, sent LSB first.
- `ready_tx_out`, output, 1: block can accept a word.
- `sdata_tx_out`, output, 1: serial line, idle high.
- `busy_tx_out`, output, 1: a frame is on the line.
- `done_tx_out`, output, 1: one-cycle pulse when a frame completes.

## Operation
- Bit period: `CLKS_PER_BIT = CLOCK_INPUT / BAUDRATE`, integer floor.
  - Elaboration error if `CLKS_PER_BIT < 2`, or if `DATA_BITS` / `STOP_BITS` / `PARITY` are out of range.
- Baud counter: width `$clog2(CLKS_PER_BIT)`.
  - Cleared to 0 on handshake.
  - Otherwise counts `0..CLKS_PER_BIT-1` and wraps.
  - Bit boundary occurs when count == `CLKS_PER_BIT-1`.
- Handshake: a transfer happens when `valid_tx_in && ready_tx_out` at a rising edge. `data_tx_in` is latched into a shift register on that edge.
- `ready_tx_out` = (state == IDLE). `busy_tx_out` = !ready.
- FSM (all outputs registered):
  - IDLE: line 1. On handshake go to START.
  - START: line 0 for one bit period, then DATA.
  - DATA: line = shift[0]; shift right at each boundary. After `DATA_BITS` bits, go to PARITY if enabled, else STOP.
  - PARITY: line = `^data` (even) or `~^data` (odd) for one bit period, then STOP.
  - STOP: line 1 for `STOP_BITS` bit periods, then IDLE. `done_tx_out` pulses in the first IDLE cycle.
- `data_tx_in` and `valid_tx_in` are don't-care outside IDLE. Changes during a frame never alter it.
- `valid_tx_in` high during reset: ignored, no frame starts.
- Reset mid-frame: on the first edge with `nreset` low, the frame is aborted.
  - `sdata_tx_out`=1, `ready_tx_out`=1, `busy_tx_out`=0, `done_tx_out`=0, counters 0.
  - No done pulse is generated for the aborted frame.
- Reset values: `sdata_tx_out`=1, `ready_tx_out`=1, `busy_tx_out`=0, `done_tx_out`=0.

## Timing
- Take the handshake edge as cycle 0. The start bit drives cycles 1..`CLKS_PER_BIT`.
- Frame length N = `(1 + DATA_BITS + P + STOP_BITS) * CLKS_PER_BIT`, where P = 1 if parity is active, else 0.
- Last stop-bit cycle is N. IDLE, `done_tx_out`=1 and `ready_tx_out`=1 all occur in cycle N+1.
- Back-to-back: with `valid_tx_in` held high, the next handshake lands in cycle N+1. Frame period is N+1 cycles, giving one extra idle-high clock between frames.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity logic are compiled in, and `PARITY` selects none/odd/even.
- Not defined: no parity hardware, P = 0 always, `PARITY` is ignored. The frame is `DATA_BITS`N`STOP_BITS`.

## Structure
- Package `uart_pkg` holds:
  - `parity_e` enum (NONE, ODD, EVEN).
  - `tx_state_e` enum (IDLE, START, DATA, PARITY, STOP).
  - A `clks_per_bit` constant function.
- Sub-module `uart_baud_tick`: synchronous clear input, one-cycle tick output at each bit boundary. It is parametrised by `CLKS_PER_BIT`.

## Test plan
All cases use `CLOCK_INPUT`=460800 and `BAUDRATE`=115200, giving `CLKS_PER_BIT`=4.
- 8N1, send 0xA5: line shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. `done_tx_out` pulses at cycle 41 only.
- `UART_TX_PARITY_EN`, 8 data bits:
  - `PARITY`=2, send 0x07: parity bit 1.
  - `PARITY`=1, send 0x07: parity bit 0.
  - In both cases `done_tx_out` pulses at cycle 45.
- `valid_tx_in` held high, words 0x55 then 0xAA: second handshake at cycle 41, second start bit at cycles 42..45. The 0xAA data is unaffected by input changes during the first frame.
- `DATA_BITS`=7, `STOP_BITS`=2, send 0x7F: seven 1 bits, then stop high for 8 cycles. `done_tx_out` pulses at cycle 41.
- Reset asserted at cycle 15 of a frame: next edge gives `sdata_tx_out`=1, `ready_tx_out`=1, `busy_tx_out`=0. No `done_tx_out` pulse follows.
- `valid_tx_in` low for 100 cycles after reset: line stays 1, ready stays 1, no done pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic int clks_per_bit(input int clock_hz, input int baud);
    return clock_hz / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period clock enable: counts 0..CLKS_PER_BIT-1 and flags the last count.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic nreset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!nreset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Configurable UART transmitter (data width, stop bits, optional parity).
// Parity hardware is present only when UART_TX_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY      = 0,
  parameter int CLOCK_INPUT = 50_000_000,
  parameter int BAUDRATE    = 115200
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 valid_tx_in,
  input  logic [DATA_BITS-1:0] data_tx_in,
  output logic                 ready_tx_out,
  output logic                 sdata_tx_out,
  output logic                 busy_tx_out,
  output logic                 done_tx_out,
  output logic [2:0]           state_dbg
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_INPUT, BAUDRATE);
  localparam int BCW          = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_err_cpb
    $error("uart_tx_frame: CLOCK_INPUT/BAUDRATE must give at least 2 clocks per bit");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > int'(EVEN)) begin : g_err_par
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end

  // Handshake: a word transfers on any rising edge where valid and ready are
  // both high; ready is high exactly while the FSM is idle.
  tx_state_e            state;
  logic [DATA_BITS-1:0] shift;
  logic [BCW-1:0]       bit_cnt;
  logic                 stop_cnt;
  logic                 tick;
  logic                 hs;

  assign hs        = valid_tx_in && ready_tx_out;
  assign state_dbg = state;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock (clock),
    .nreset(nreset),
    .clear (hs),
    .tick  (tick)
  );

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY != int'(NONE));
  logic par_bit;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      par_bit <= 1'b0;
    end else if (hs) begin
      par_bit <= (PARITY == int'(EVEN)) ? ^data_tx_in : ~^data_tx_in;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state        <= IDLE;
      sdata_tx_out <= 1'b1;
      ready_tx_out <= 1'b1;
      busy_tx_out  <= 1'b0;
      done_tx_out  <= 1'b0;
      shift        <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
    end else begin
      done_tx_out <= 1'b0;
      case (state)
        IDLE: begin
          sdata_tx_out <= 1'b1;
          if (hs) begin
            shift        <= data_tx_in;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            sdata_tx_out <= 1'b0;
            ready_tx_out <= 1'b0;
            busy_tx_out  <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          if (tick) begin
            sdata_tx_out <= shift[0];
            state        <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              if (PAR_ON) begin
                sdata_tx_out <= par_bit;
                state        <= uart_pkg::PARITY;
              end else begin
                sdata_tx_out <= 1'b1;
                state        <= STOP;
              end
`else
              sdata_tx_out <= 1'b1;
              state        <= STOP;
`endif
            end else begin
              // Drive the next bit now so the line changes on the boundary.
              shift        <= shift >> 1;
              sdata_tx_out <= shift[1];
              bit_cnt      <= bit_cnt + BCW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        uart_pkg::PARITY: begin
          if (tick) begin
            sdata_tx_out <= 1'b1;
            state        <= STOP;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              sdata_tx_out <= 1'b1;
              ready_tx_out <= 1'b1;
              busy_tx_out  <= 1'b0;
              done_tx_out  <= 1'b1;
              state        <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          sdata_tx_out <= 1'b1;
          ready_tx_out <= 1'b1;
          busy_tx_out  <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame tables plus back-to-back and reset sequences.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int CLK_HZ = 460800;
  localparam int BAUD   = 115200;
  localparam int CPB    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NDUT = 4;
`else
  localparam int NDUT = 2;
`endif

  logic       clock  = 1'b0;
  logic       nreset = 1'b0;
  logic       valid  = 1'b0;
  logic [8:0] data   = '0;

  logic       sd [NDUT];
  logic       rd [NDUT];
  logic       bz [NDUT];
  logic       dn [NDUT];
  logic [2:0] st [NDUT];

  always #5 clock = ~clock;

  // 0: 8N1, 1: 7N2, 2: 8E1, 3: 8O1
  uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(0),
                  .CLOCK_INPUT(CLK_HZ), .BAUDRATE(BAUD)) dut_8n1 (
    .clock(clock), .nreset(nreset), .valid_tx_in(valid), .data_tx_in(data[7:0]),
    .ready_tx_out(rd[0]), .sdata_tx_out(sd[0]), .busy_tx_out(bz[0]),
    .done_tx_out(dn[0]), .state_dbg(st[0]));

  uart_tx_frame #(.DATA_BITS(7), .STOP_BITS(2), .PARITY(0),
                  .CLOCK_INPUT(CLK_HZ), .BAUDRATE(BAUD)) dut_7n2 (
    .clock(clock), .nreset(nreset), .valid_tx_in(valid), .data_tx_in(data[6:0]),
    .ready_tx_out(rd[1]), .sdata_tx_out(sd[1]), .busy_tx_out(bz[1]),
    .done_tx_out(dn[1]), .state_dbg(st[1]));

`ifdef UART_TX_PARITY_EN
  uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(2),
                  .CLOCK_INPUT(CLK_HZ), .BAUDRATE(BAUD)) dut_8e1 (
    .clock(clock), .nreset(nreset), .valid_tx_in(valid), .data_tx_in(data[7:0]),
    .ready_tx_out(rd[2]), .sdata_tx_out(sd[2]), .busy_tx_out(bz[2]),
    .done_tx_out(dn[2]), .state_dbg(st[2]));

  uart_tx_frame #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(1),
                  .CLOCK_INPUT(CLK_HZ), .BAUDRATE(BAUD)) dut_8o1 (
    .clock(clock), .nreset(nreset), .valid_tx_in(valid), .data_tx_in(data[7:0]),
    .ready_tx_out(rd[3]), .sdata_tx_out(sd[3]), .busy_tx_out(bz[3]),
    .done_tx_out(dn[3]), .state_dbg(st[3]));
`endif

  // exp_bits[i] is the line level during bit period i (start bit at index 0).
  typedef struct {
    string       name;
    int          sel;
    logic [8:0]  data;
    int          nbits;
    logic [15:0] exp_bits;
    int          done_cycle;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add_vec(input string name, input int sel, input logic [8:0] d,
                         input int nbits, input logic [15:0] bits, input int done_c);
    vec_t v;
    v.name       = name;
    v.sel        = sel;
    v.data       = d;
    v.nbits      = nbits;
    v.exp_bits   = bits;
    v.done_cycle = done_c;
    vecs.push_back(v);
  endtask

  task automatic chk_bit(input string name, input int c, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input int c, input logic [15:0] act,
                         input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_check(input string name, input int cycles);
    for (int c = 1; c <= cycles; c++) begin
      for (int d = 0; d < NDUT; d++) begin
        chk_bit({name, " line"}, c, sd[d], 1'b1);
        chk_bit({name, " ready"}, c, rd[d], 1'b1);
        chk_bit({name, " done"}, c, dn[d], 1'b0);
      end
      next_cycle();
    end
  endtask

  // Cycle c is the clock period following handshake edge c-1.
  task automatic run_vec(input vec_t v);
    int   n;
    logic el;
    n = v.nbits * CPB;
    @(negedge clock);
    valid = 1'b1;
    data  = v.data;
    next_cycle();
    valid = 1'b0;
    for (int c = 1; c <= n + 4; c++) begin
      el = (c <= n) ? v.exp_bits[(c - 1) / CPB] : 1'b1;
      chk_bit({v.name, " line"}, c, sd[v.sel], el);
      chk_bit({v.name, " done"}, c, dn[v.sel], c == v.done_cycle);
      chk_bit({v.name, " ready"}, c, rd[v.sel], c > n);
      chk_bit({v.name, " busy"}, c, bz[v.sel], c <= n);
      next_cycle();
    end
    repeat (10) next_cycle();
  endtask

  initial begin
    logic [15:0] p55;
    logic [15:0] paa;
    logic [15:0] pa5;
    logic        el;

    // Reset with valid asserted must not start a frame.
    nreset = 1'b0;
    valid  = 1'b1;
    data   = 9'h1FF;
    repeat (3) next_cycle();
    for (int d = 0; d < NDUT; d++) begin
      chk_bit("reset line", 0, sd[d], 1'b1);
      chk_bit("reset ready", 0, rd[d], 1'b1);
      chk_bit("reset busy", 0, bz[d], 1'b0);
      chk_bit("reset done", 0, dn[d], 1'b0);
      chk_vec("reset state", 0, 16'(st[d]), 16'(IDLE));
    end
    nreset = 1'b1;
    valid  = 1'b0;
    idle_check("post-reset idle", 100);

    add_vec("8n1 a5", 0, 9'h0A5, 10, 16'b1101001010, 41);
    add_vec("8n1 3c", 0, 9'h03C, 10, 16'b1001111000, 41);
    add_vec("8n1 00", 0, 9'h000, 10, 16'b1000000000, 41);
    add_vec("8n1 ff", 0, 9'h0FF, 10, 16'b1111111110, 41);
    add_vec("7n2 7f", 1, 9'h07F, 10, 16'b1111111110, 41);
    add_vec("7n2 2a", 1, 9'h02A, 10, 16'b1101010100, 41);
`ifdef UART_TX_PARITY_EN
    add_vec("8e1 07", 2, 9'h007, 11, 16'b11000001110, 45);
    add_vec("8o1 07", 3, 9'h007, 11, 16'b10000001110, 45);
`endif
    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: valid held, data disturbed mid-frame.
    p55 = 16'b1010101010;
    paa = 16'b1101010100;
    @(negedge clock);
    valid = 1'b1;
    data  = 9'h055;
    next_cycle();
    for (int c = 1; c <= 90; c++) begin
      if (c <= 40)      el = p55[(c - 1) / CPB];
      else if (c == 41) el = 1'b1;
      else if (c <= 81) el = paa[(c - 42) / CPB];
      else              el = 1'b1;
      chk_bit("b2b line", c, sd[0], el);
      chk_bit("b2b done", c, dn[0], (c == 41) || (c == 82));
      chk_bit("b2b ready", c, rd[0], (c == 41) || (c >= 82));
      if (c == 10) data = 9'h1FF;
      if (c == 30) data = 9'h0AA;
      if (c == 42) begin
        valid = 1'b0;
        data  = 9'h000;
      end
      next_cycle();
    end
    repeat (10) next_cycle();

    // Reset in the middle of a frame aborts it without a done pulse.
    pa5 = 16'b1101001010;
    @(negedge clock);
    valid = 1'b1;
    data  = 9'h0A5;
    next_cycle();
    valid = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      chk_bit("abort pre line", c, sd[0], pa5[(c - 1) / CPB]);
      if (c == 15) begin
        nreset = 1'b0;
        valid  = 1'b1;
      end
      next_cycle();
    end
    for (int c = 16; c <= 17; c++) begin
      chk_bit("abort line", c, sd[0], 1'b1);
      chk_bit("abort ready", c, rd[0], 1'b1);
      chk_bit("abort busy", c, bz[0], 1'b0);
      chk_bit("abort done", c, dn[0], 1'b0);
      chk_vec("abort state", c, 16'(st[0]), 16'(IDLE));
      if (c == 17) begin
        nreset = 1'b1;
        valid  = 1'b0;
      end
      next_cycle();
    end
    idle_check("post-abort idle", 60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
